// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared definitions for the bus transfer sequencer: FSM state encoding
// and default register-bank sizes.
package bus_xfer_ctrl_pkg;

    localparam int NUM_REGS_DEF = 8;
    localparam int NUM_AR_DEF   = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRIVE  = 3'd1;
    localparam state_t ST_WRITE  = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_ACKERR = 3'd4;

endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Index-to-one-hot decoder with enable; output is all zero when disabled
// or when the index is beyond the decoded range.
module onehot_dec #(
    parameter int IDX_W = 3,
    parameter int N     = 8
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N-1:0]     oh_o
);

    // Compare the index against every output position.
    always_comb begin
        oh_o = '0;
        for (int i = 0; i < N; i++) begin
            oh_o[i] = en_i && (idx_i == IDX_W'(i));
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register move sequencer for the shared tristate data bus.
// Strobes are decoded only from registered state and registered selects,
// so nothing on the request inputs can glitch the bus drivers.
module bus_xfer_ctrl
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = NUM_REGS_DEF,
    parameter int SEL_WIDTH    = 3,
    parameter int NUM_AR       = NUM_AR_DEF,
    parameter int AR_SEL_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    wide,
    input  logic [SEL_WIDTH-1:0]    src_sel,
    input  logic [SEL_WIDTH-1:0]    dst_sel,
    input  logic [AR_SEL_WIDTH-1:0] ar_sel,
    output logic                    busy,
    output logic                    ack,
    output logic                    err,
    output logic [NUM_REGS-1:0]     reg_cs,
    output logic [NUM_REGS-1:0]     reg_oe,
    output logic [NUM_REGS-1:0]     reg_we,
    output logic [NUM_AR-1:0]       ar_cs,
    output logic                    ar_we_l,
    output logic                    ar_we_h
);

    state_t                  state_q, state_d;
    logic                    phase_q, phase_d;
    logic                    wide_q;
    logic [SEL_WIDTH-1:0]    src_q, dst_q;
    logic [AR_SEL_WIDTH-1:0] ar_q;
    logic                    cap;
    logic                    cmd_bad;
    logic                    active;
    logic [SEL_WIDTH-1:0]    cur_src;
    logic [NUM_REGS-1:0]     src_oh, dst_oh;
    logic [NUM_AR-1:0]       ar_oh;
    logic [31:0]             src_ext, dst_ext, ar_ext;

    assign src_ext = 32'(src_sel);
    assign dst_ext = 32'(dst_sel);
    assign ar_ext  = 32'(ar_sel);

    // Reject self-moves, out-of-range indices and a wide load with no pair partner.
    always_comb begin
        if (wide) begin
            cmd_bad = (src_ext >= 32'(NUM_REGS - 1)) || (ar_ext >= 32'(NUM_AR));
        end else begin
            cmd_bad = (src_sel == dst_sel) || (src_ext >= 32'(NUM_REGS)) ||
                      (dst_ext >= 32'(NUM_REGS));
        end
    end

    // Transfer sequencing: DRIVE (settle), WRITE (capture), HOLD (latch close).
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cap     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cap     = 1'b1;
                    phase_d = 1'b0;
                    state_d = cmd_bad ? ST_ACKERR : ST_DRIVE;
                end
            end
            ST_DRIVE: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (wide_q && !phase_q) begin
                    phase_d = 1'b1;
                    state_d = ST_DRIVE;
                end else begin
                    phase_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACKERR: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                phase_d = 1'b0;
            end
        endcase
    end

    // Control state; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Command capture; only loaded in IDLE so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (cap) begin
            wide_q <= wide;
            src_q  <= src_sel;
            dst_q  <= dst_sel;
            ar_q   <= ar_sel;
        end
    end

    assign active  = (state_q == ST_DRIVE) || (state_q == ST_WRITE) || (state_q == ST_HOLD);
    // Phase 1 of a wide load reads the upper register of the pair.
    assign cur_src = src_q + SEL_WIDTH'(phase_q);

    onehot_dec #(.IDX_W(SEL_WIDTH), .N(NUM_REGS)) u_src_dec (
        .idx_i (cur_src),
        .en_i  (active),
        .oh_o  (src_oh)
    );

    onehot_dec #(.IDX_W(SEL_WIDTH), .N(NUM_REGS)) u_dst_dec (
        .idx_i (dst_q),
        .en_i  (active && !wide_q),
        .oh_o  (dst_oh)
    );

    onehot_dec #(.IDX_W(AR_SEL_WIDTH), .N(NUM_AR)) u_ar_dec (
        .idx_i (ar_q),
        .en_i  (active && wide_q),
        .oh_o  (ar_oh)
    );

    assign reg_oe  = src_oh;
    assign reg_cs  = src_oh | dst_oh;
    assign reg_we  = (state_q == ST_WRITE) ? dst_oh : '0;
    assign ar_cs   = ar_oh;
    assign ar_we_l = (state_q == ST_WRITE) && wide_q && !phase_q;
    assign ar_we_h = (state_q == ST_WRITE) && wide_q && phase_q;
    assign busy    = (state_q != ST_IDLE);
    assign ack     = ((state_q == ST_HOLD) && (!wide_q || phase_q)) || (state_q == ST_ACKERR);
    assign err     = (state_q == ST_ACKERR);

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: a per-cycle schedule model plus
// directed literal checks and randomized command traffic.
module tb_bus_xfer_ctrl;

    localparam int NR = 8;
    localparam int SW = 3;
    localparam int NA = 2;
    localparam int AW = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          wide = 1'b0;
    logic [SW-1:0] src_sel = '0;
    logic [SW-1:0] dst_sel = '0;
    logic [AW-1:0] ar_sel = '0;
    logic          busy, ack, err, ar_we_l, ar_we_h;
    logic [NR-1:0] reg_cs, reg_oe, reg_we;
    logic [NA-1:0] ar_cs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.NUM_REGS(NR), .SEL_WIDTH(SW), .NUM_AR(NA), .AR_SEL_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .wide(wide), .src_sel(src_sel),
        .dst_sel(dst_sel), .ar_sel(ar_sel), .busy(busy), .ack(ack), .err(err),
        .reg_cs(reg_cs), .reg_oe(reg_oe), .reg_we(reg_we), .ar_cs(ar_cs),
        .ar_we_l(ar_we_l), .ar_we_h(ar_we_h)
    );

    typedef struct packed {
        logic [NR-1:0] cs;
        logic [NR-1:0] oe;
        logic [NR-1:0] we;
        logic [NA-1:0] arcs;
        logic          wl;
        logic          wh;
        logic          busy;
        logic          ack;
        logic          err;
    } exp_t;

    exp_t       cur = '0;
    exp_t       sched[$];
    logic [30:0] dut_v;
    assign dut_v = {reg_cs, reg_oe, reg_we, ar_cs, ar_we_l, ar_we_h, busy, ack, err};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs of a whole command, from the bus protocol rules.
    function automatic void build(input logic w, input int s, input int d, input int a);
        exp_t e;
        bit   bad;
        int   nph;
        if (!w) bad = (s == d) || (s >= NR) || (d >= NR);
        else    bad = (s >= NR - 1) || (a >= NA);
        if (bad) begin
            e = '0; e.busy = 1'b1; e.ack = 1'b1; e.err = 1'b1;
            sched.push_back(e);
            return;
        end
        nph = w ? 2 : 1;
        for (int ph = 0; ph < nph; ph++) begin
            for (int c = 0; c < 3; c++) begin
                e      = '0;
                e.busy = 1'b1;
                e.oe   = NR'(1) << (s + ph);
                e.cs   = e.oe | (w ? '0 : (NR'(1) << d));
                e.we   = (!w && c == 1) ? (NR'(1) << d) : '0;
                e.arcs = w ? (NA'(1) << a) : '0;
                e.wl   = w && ph == 0 && c == 1;
                e.wh   = w && ph == 1 && c == 1;
                e.ack  = (c == 2) && (ph == nph - 1);
                sched.push_back(e);
            end
        end
    endfunction

    // Reference: advance one cycle of the schedule, or accept a new command when idle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur = '0;
            sched.delete();
        end else if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else if (!cur.busy && req) begin
            build(wide, int'(src_sel), int'(dst_sel), int'(ar_sel));
            cur = sched.pop_front();
        end else begin
            cur = '0;
        end
    end

    // Compare every cycle, plus bus-contention and single-write checks.
    always @(negedge clk) begin
        if (reset) begin
            chk("model", 64'(dut_v), 64'(cur));
            chk("oe_excl", 64'($countones(reg_oe) <= 1), 64'(1));
            chk("we_excl", 64'(($countones(reg_we) + int'(ar_we_l) + int'(ar_we_h)) <= 1), 64'(1));
        end
    end

    task automatic rand_fields();
        wide    = 1'($urandom_range(0, 1));
        src_sel = SW'($urandom_range(0, NR - 1));
        dst_sel = SW'($urandom_range(0, NR - 1));
        ar_sel  = AW'($urandom_range(0, NA - 1));
    endtask

    task automatic wait_ack(input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (ack) begin
                ok = 1'b1;
                break;
            end
            rand_fields();
        end
        chk(nm, 64'(ok), 64'(1));
    endtask

    task automatic issue(input logic w, input int s, input int d, input int a);
        @(negedge clk);
        req = 1'b1; wide = w; src_sel = SW'(s); dst_sel = SW'(d); ar_sel = AW'(a);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b0;
        #1 chk("reset_outputs", 64'(dut_v), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Narrow move 2 -> 5, selects scrambled while busy.
        issue(1'b0, 2, 5, 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("n_oe", 64'(reg_oe), 64'h04);
            chk("n_cs", 64'(reg_cs), 64'h24);
            chk("n_we", 64'(reg_we), (c == 2) ? 64'h20 : 64'h00);
            chk("n_ack", 64'(ack), 64'(c == 3));
            chk("n_busy", 64'(busy), 64'(1));
            if (c < 3) rand_fields(); else req = 1'b0;
        end
        @(negedge clk);
        chk("n_idle_busy", 64'(busy), 64'(0));
        chk("n_idle_oe", 64'(reg_oe), 64'(0));

        // Wide load from pair 3/4 into AR1.
        issue(1'b1, 3, 0, 1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("w_oe", 64'(reg_oe), (c <= 3) ? 64'h08 : 64'h10);
            chk("w_arcs", 64'(ar_cs), 64'h2);
            chk("w_wel", 64'(ar_we_l), 64'(c == 2));
            chk("w_weh", 64'(ar_we_h), 64'(c == 5));
            chk("w_ack", 64'(ack), 64'(c == 6));
            if (c < 6) rand_fields(); else req = 1'b0;
        end

        // Rejects: self move, then wide with no pair partner.
        @(negedge clk);
        issue(1'b0, 4, 4, 0);
        @(negedge clk);
        req = 1'b0;
        chk("rej1", 64'({busy, ack, err}), 64'h7);
        chk("rej1_strobes", 64'(dut_v[30:3]), 64'(0));
        @(negedge clk);
        issue(1'b1, 7, 0, 0);
        @(negedge clk);
        req = 1'b0;
        chk("rej2", 64'({busy, ack, err}), 64'h7);
        chk("rej2_strobes", 64'(dut_v[30:3]), 64'(0));
        @(negedge clk);

        // Back-to-back: req held across ack, new command 6 -> 3.
        issue(1'b0, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk("b2b_ack1", 64'(ack), 64'(1));
        wide = 1'b0; src_sel = 3'd6; dst_sel = 3'd3;
        @(negedge clk);
        chk("b2b_gap", 64'({busy, reg_oe}), 64'(0));
        @(negedge clk);
        chk("b2b_second", 64'(reg_oe), 64'h40);
        req = 1'b0;
        wait_ack("b2b_ack2");

        // Reset during WRITE of wide phase 1.
        @(negedge clk);
        issue(1'b1, 0, 0, 0);
        repeat (5) @(negedge clk);
        chk("rst_in_write", 64'(ar_we_h), 64'(1));
        #2 reset = 1'b0;
        #1 chk("rst_async", 64'(dut_v), 64'(0));
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_idle", 64'({busy, ack}), 64'(0));
        issue(1'b0, 1, 6, 0);
        wait_ack("post_rst_ack");
        chk("post_rst_err", 64'(err), 64'(0));
        req = 1'b0;

        // Randomized traffic, sometimes back-to-back.
        for (int t = 0; t < 250; t++) begin
            if (!req) begin
                @(negedge clk);
                rand_fields();
                req = 1'b1;
            end
            wait_ack("rand_ack");
            if ($urandom_range(0, 1) == 1) rand_fields();
            else req = 1'b0;
        end
        req = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
